// File: rtl/add4_bist.sv
// add4_bist: exhaustive stimulus generator and response checker for a four-operand adder.
// Operand vector {d,c,b,a} sweeps 0..all-ones; the result is compared against a golden sum one cycle after sampling.
module add4_bist #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [W-1:0]   op_c,
    output logic [W-1:0]   op_d,
    input  logic [W-1:0]   dut_sum,
    input  logic           dut_ov,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [4*W:0]   fail_cnt,
    output logic [4*W-1:0] first_fail_vec,
    output logic           first_fail_vld
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    state_t         state;
    logic [4*W-1:0] v;
    logic [SW-1:0]  settle;
    logic [W+1:0]   s;
    logic           miss;
    logic           chk_vld;
    logic           chk_miss;
    logic           chk_last;
    logic [4*W-1:0] chk_vec;
    assign {op_d, op_c, op_b, op_a} = v;
    assign s    = (W+2)'(op_a) + (W+2)'(op_b) + (W+2)'(op_c) + (W+2)'(op_d);
    assign miss = {dut_ov, dut_sum} != {|s[W+1:W], s[W-1:0]};
    assign pass = done && fail_cnt == '0;
    // The sampled result is scored one edge after CHECK, so done and busy settle together with the final count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            v              <= '0;
            settle         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
            chk_vld        <= 1'b0;
            chk_miss       <= 1'b0;
            chk_last       <= 1'b0;
            chk_vec        <= '0;
        end else begin
            chk_vld <= 1'b0;
            if (chk_vld) begin
                if (chk_miss) begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_vec <= chk_vec;
                    end
                end
                if (chk_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start && !abort && !busy) begin
                        state          <= APPLY;
                        v              <= '0;
                        settle         <= '0;
                        fail_cnt       <= '0;
                        first_fail_vec <= '0;
                        first_fail_vld <= 1'b0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (settle == SW'(SETTLE - 1)) begin
                        state  <= CHECK;
                        settle <= '0;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        chk_vld  <= 1'b1;
                        chk_miss <= miss;
                        chk_vec  <= v;
                        chk_last <= &v;
                        state    <= &v ? DONE : APPLY;
                        v        <= &v ? v : v + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
